// File: rtl/pwls_multichannel_osc.sv
// Time-multiplexed multichannel oscillator (saw / triangle / square).
// Each channel takes two sequencer slots: step A advances its phase and
// step B turns that phase into a waveform, scales it by the channel
// amplitude through one shared multiplier and adds it to the frame
// accumulator. The last slot of a frame publishes the mixed sample.
module pwls_multichannel_osc #(
  parameter int BITS         = 12,
  parameter int NUM_CHANNELS = 4,
  parameter int OCT_BITS     = 3,
  parameter int AMP_BITS     = 10,
  parameter int OUT_BITS     = BITS + $clog2(NUM_CHANNELS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  run,
  input  logic                                  cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0]       cfg_chan,
  input  logic [2:0]                            cfg_addr,
  input  logic [BITS-1:0]                       cfg_data,
  output logic signed [OUT_BITS-1:0]            sample_out,
  output logic                                  sample_valid,
  output logic [$clog2(2*NUM_CHANNELS)-1:0]     slot_out
);

  localparam int CH_W   = $clog2(NUM_CHANNELS);
  localparam int SLOT_W = $clog2(2*NUM_CHANNELS);
  localparam int PROD_W = BITS + AMP_BITS + 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2*NUM_CHANNELS-1);
  localparam logic [BITS-1:0]   HALF      = {1'b1, {(BITS-1){1'b0}}};

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;
  localparam logic [1:0] MODE_SQR = 2'd3;

  // Signed waveform value for a given mode and phase. Subtracting
  // 2^(BITS-1) modulo 2^BITS is the same as flipping the MSB.
  function automatic logic signed [BITS-1:0] wave_of(input logic [1:0]      mode,
                                                      input logic [BITS-1:0] p);
    logic [BITS-2:0] t;
    logic [BITS-1:0] r;
    t = p[BITS-1] ? ~p[BITS-2:0] : p[BITS-2:0];
    case (mode)
      MODE_SAW: r = p ^ HALF;
      MODE_TRI: r = {t, 1'b0} ^ HALF;
      MODE_SQR: r = p[BITS-1] ? ~HALF : HALF;
      default:  r = '0;
    endcase
    return signed'(r);
  endfunction

  // Floor-scale the amplitude product back to waveform range. The result
  // always fits in BITS signed bits, so resizing to OUT_BITS is lossless.
  function automatic logic signed [OUT_BITS-1:0] scale_floor(input logic signed [PROD_W-1:0] prod);
    return OUT_BITS'(prod >>> AMP_BITS);
  endfunction

  // Per-channel configuration and phase state
  logic [BITS-2:0]     mant_q  [NUM_CHANNELS];
  logic [OCT_BITS-1:0] oct_q   [NUM_CHANNELS];
  logic [AMP_BITS-1:0] amp_q   [NUM_CHANNELS];
  logic [1:0]          mode_q  [NUM_CHANNELS];
  logic [BITS-1:0]     phase_q [NUM_CHANNELS];

  // Sequencer state
  logic [SLOT_W-1:0]          slot_q,       slot_d;
  logic signed [OUT_BITS-1:0] acc_q,        acc_d;
  logic signed [OUT_BITS-1:0] sample_out_q, sample_out_d;
  logic                       valid_q,      valid_d;

  logic [CH_W-1:0]            ch;
  logic                       step_b;
  logic                       cfg_ok;
  logic [BITS-1:0]            phase_inc;
  logic [BITS-1:0]            phase_d;
  logic signed [BITS-1:0]     w;
  logic signed [PROD_W-1:0]   prod;
  logic signed [OUT_BITS-1:0] term;
  logic signed [OUT_BITS-1:0] acc_sum;

  // Slot LSB selects the step, the upper bits select the channel.
  assign ch     = slot_q[SLOT_W-1:1];
  assign step_b = slot_q[0];
  assign cfg_ok = cfg_we && (int'(cfg_chan) < NUM_CHANNELS);

  // Step A: octave is a right shift of the implicit-one mantissa; the
  // shift distance (2^OCT_BITS-1-octave) is just the bitwise inverse.
  assign phase_inc = {1'b1, mant_q[ch]} >> (~oct_q[ch]);
  assign phase_d   = (mode_q[ch] == MODE_OFF) ? '0 : phase_q[ch] + phase_inc;

  // Step B: one shared multiplier, amplitude treated as unsigned.
  assign w       = wave_of(mode_q[ch], phase_q[ch]);
  assign prod    = w * $signed({1'b0, amp_q[ch]});
  assign term    = scale_floor(prod);
  assign acc_sum = acc_q + term;

  // Next-state for the slot counter, accumulator and output sample
  always_comb begin
    slot_d       = slot_q;
    acc_d        = acc_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    if (run) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
      if (step_b) begin
        if (slot_q == LAST_SLOT) begin
          sample_out_d = acc_sum;
          valid_d      = 1'b1;
          acc_d        = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  // Sequencer registers; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= '0;
      acc_q        <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
    end
  end

  // Channel fields: step-A phase update, then config writes (a same-cycle
  // phase write overrides the step-A result because it is assigned last)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        mant_q[i]  <= '0;
        oct_q[i]   <= '0;
        amp_q[i]   <= '0;
        mode_q[i]  <= MODE_OFF;
        phase_q[i] <= '0;
      end
    end else begin
      if (run && !step_b) begin
        phase_q[ch] <= phase_d;
      end
      if (cfg_ok) begin
        case (cfg_addr)
          3'd0:    mant_q[cfg_chan]  <= cfg_data[BITS-2:0];
          3'd1:    oct_q[cfg_chan]   <= cfg_data[OCT_BITS-1:0];
          3'd2:    amp_q[cfg_chan]   <= cfg_data[AMP_BITS-1:0];
          3'd3:    mode_q[cfg_chan]  <= cfg_data[1:0];
          3'd4:    phase_q[cfg_chan] <= cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = valid_q;
  assign slot_out     = slot_q;

endmodule

// File: tb/tb_pwls_multichannel_osc.sv
// Self-checking bench for pwls_multichannel_osc: directed scenarios with
// literal expectations plus a randomized run, all checked every cycle
// against a frame/slot-level arithmetic model of the oscillator.
module tb_pwls_multichannel_osc;

  localparam int BITS = 12;
  localparam int NC   = 4;
  localparam int OCT  = 3;
  localparam int AMP  = 10;
  localparam int OUTB = BITS + $clog2(NC);
  localparam int NSLOT = 2 * NC;
  localparam int PMOD  = 2 ** BITS;
  localparam int HALF  = 2 ** (BITS - 1);

  logic                 clk;
  logic                 reset;
  logic                 run;
  logic                 cfg_we;
  logic [1:0]           cfg_chan;
  logic [2:0]           cfg_addr;
  logic [BITS-1:0]      cfg_data;
  logic signed [OUTB-1:0] sample_out;
  logic                 sample_valid;
  logic [2:0]           slot_out;

  pwls_multichannel_osc #(
    .BITS(BITS), .NUM_CHANNELS(NC), .OCT_BITS(OCT), .AMP_BITS(AMP)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .slot_out(slot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mant [NC];
  int m_oct  [NC];
  int m_amp  [NC];
  int m_mode [NC];
  int m_phase[NC];
  int m_slot, m_acc, m_out;
  int m_valid;

  function automatic int m_wave(int mode, int p);
    int t;
    case (mode)
      1: return p - HALF;
      2: begin
        t = (p >= HALF) ? (HALF - 1 - (p % HALF)) : (p % HALF);
        return 2 * t - HALF;
      end
      3: return (p >= HALF) ? HALF - 1 : -HALF;
      default: return 0;
    endcase
  endfunction

  function automatic int floor_div(int x, int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  task automatic model_step();
    int c, term;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        m_mant[i] = 0; m_oct[i] = 0; m_amp[i] = 0; m_mode[i] = 0; m_phase[i] = 0;
      end
      m_slot = 0; m_acc = 0; m_out = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (run) begin
        c = m_slot / 2;
        if (m_slot % 2 == 0) begin
          if (m_mode[c] == 0) m_phase[c] = 0;
          else m_phase[c] = (m_phase[c] + ((HALF + m_mant[c]) >> ((2 ** OCT - 1) - m_oct[c]))) % PMOD;
        end else begin
          term = floor_div(m_wave(m_mode[c], m_phase[c]) * m_amp[c], 2 ** AMP);
          if (m_slot == NSLOT - 1) begin
            m_out = m_acc + term; m_valid = 1; m_acc = 0;
          end else begin
            m_acc = m_acc + term;
          end
        end
        m_slot = (m_slot + 1) % NSLOT;
      end
      if (cfg_we && int'(cfg_chan) < NC) begin
        case (int'(cfg_addr))
          0: m_mant[cfg_chan]  = int'(cfg_data) % HALF;
          1: m_oct[cfg_chan]   = int'(cfg_data) % (2 ** OCT);
          2: m_amp[cfg_chan]   = int'(cfg_data) % (2 ** AMP);
          3: m_mode[cfg_chan]  = int'(cfg_data) % 4;
          4: m_phase[cfg_chan] = int'(cfg_data);
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compare();
    check("slot_out", int'(slot_out), m_slot);
    check("sample_valid", int'(sample_valid), m_valid);
    check("sample_out", int'(sample_out), m_out);
  endtask

  // One clock: DUT and model both consume the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic cfg_write(int ch, int addr, int data);
    cfg_we = 1'b1; cfg_chan = 2'(ch); cfg_addr = 3'(addr); cfg_data = BITS'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic cfg_square(int ch);
    cfg_write(ch, 3, 3);
    cfg_write(ch, 1, 7);
    cfg_write(ch, 0, 0);
    cfg_write(ch, 2, 1023);
  endtask

  task automatic wait_valid(output int val);
    bit got;
    got = 1'b0;
    val = 0;
    for (int i = 0; i < 3 * NSLOT && !got; i++) begin
      tick();
      if (sample_valid) begin
        got = 1'b1;
        val = int'(sample_out);
      end
    end
    check("valid_within_budget", int'(got), 1);
  endtask

  int v, cnt;
  bit got;

  initial begin
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0;
    cfg_chan = '0; cfg_addr = '0; cfg_data = '0;

    // Idle run: pulses every frame with zero output
    do_reset();
    check("reset_slot", int'(slot_out), 0);
    check("reset_out", int'(sample_out), 0);
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 * NSLOT; i++) begin
      tick();
      if (sample_valid) cnt++;
    end
    check("idle_valid_count", cnt, 2);
    check("idle_out", int'(sample_out), 0);

    // Single square channel
    do_reset();
    cfg_square(0);
    run = 1'b1;
    wait_valid(v); check("sq1_first", v, 2045); check("model_sq1_first", m_out, 2045);
    wait_valid(v); check("sq1_second", v, -2046);
    wait_valid(v); check("sq1_third", v, 2045);

    // Four square channels
    do_reset();
    for (int c = 0; c < NC; c++) cfg_square(c);
    run = 1'b1;
    wait_valid(v); check("sq4_first", v, 8180); check("model_sq4_first", m_out, 8180);
    wait_valid(v); check("sq4_second", v, -8184);

    // Slow saw
    do_reset();
    cfg_write(0, 3, 1);
    cfg_write(0, 1, 0);
    cfg_write(0, 0, 0);
    cfg_write(0, 2, 1023);
    run = 1'b1;
    wait_valid(v); check("saw_first", v, -2031); check("model_saw_first", m_out, -2031);
    wait_valid(v); check("saw_second", v, -2015);

    // Pause at slot 3 for 5 cycles
    do_reset();
    cfg_square(0);
    run = 1'b1;
    repeat (3) tick();
    check("pause_slot", int'(slot_out), 3);
    run = 1'b0;
    repeat (5) tick();
    check("pause_slot_held", int'(slot_out), 3);
    run = 1'b1;
    wait_valid(v); check("pause_resume_sample", v, 2045);

    // Reset mid-frame after configuring ch0
    do_reset();
    cfg_square(0);
    run = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 3 * NSLOT && !got; i++) begin
      tick();
      cnt++;
      if (sample_valid) got = 1'b1;
    end
    check("post_reset_latency", cnt, NSLOT);
    check("post_reset_out", int'(sample_out), 0);

    // Randomized config traffic, run gating and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run      = ($urandom % 8) != 0;
      cfg_we   = ($urandom % 5) == 0;
      cfg_chan = 2'($urandom % NC);
      cfg_addr = 3'($urandom % 8);
      cfg_data = BITS'($urandom);
      reset    = ($urandom % 600) == 0;
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0; run = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
